pdm_stream_ctrl: RTL
====================

PDM_STREAM_CTRL -- requirements
Module: pdm_stream_ctrl

Interface
REQ-001 Parameter SHALL be COMPRESSED, default 0, meaning 1 = one byte per sample (pcm_data_i[15:8]) and 0 = two bytes per sample (low byte, then high byte).
REQ-002 Parameter SHALL be FILL_BYTE, default 8'h00, meaning the byte sent to SPI when the FIFO is empty.
REQ-003 Port SHALL be clk, input, 1, the single system clock; all logic is on its rising edge.
REQ-004 Port SHALL be rst, input, 1, synchronous active-high reset.
REQ-005 Port SHALL be pcm_valid_i, input, 1, one-cycle strobe marking a new PCM sample.
REQ-006 Port SHALL be pcm_data_i, input, 16, PCM sample, valid with pcm_valid_i.
REQ-007 Port SHALL be spi_busy_i, input, 1, SPI slave busy flag, asynchronous to clk.
REQ-008 Port SHALL be spi_rx_valid_i, input, 1, one-cycle strobe marking a received SPI command byte.
REQ-009 Port SHALL be spi_rx_data_i, input, 8, received command byte.
REQ-010 Port SHALL be spi_tx_data_o, output, 8, next byte for the SPI slave to shift out.
REQ-011 Port SHALL be spi_tx_valid_o, output, 1, one-cycle strobe marking spi_tx_data_o as loaded.
REQ-012 Ports SHALL be fifo_wr_en_o (output, 1), fifo_wr_data_o (output, 8) and fifo_full_i (input, 1), the FIFO write side.
REQ-013 Ports SHALL be fifo_rd_en_o (output, 1), fifo_rd_data_i (input, 8) and fifo_empty_i (input, 1), the FIFO read side; read data is valid one cycle after fifo_rd_en_o.
REQ-014 Ports SHALL be capturing_o (output, 1, capture enabled), overflow_o (output, 1, sticky sample-drop flag) and drop_count_o (output, 16, dropped-sample count).

Function
REQ-015 Commands SHALL be 8'h01 START (capturing=1), 8'h02 STOP (capturing=0) and 8'h03 CLR (clear overflow_o and drop_count_o); all other bytes are ignored, and START while capturing is a no-op.
REQ-016 The writer FSM SHALL have states W_IDLE and W_HIGH.
REQ-017 In W_IDLE, pcm_valid_i && capturing && !fifo_full_i SHALL, on the next edge, latch the sample and issue one fifo_wr_en_o pulse with the low byte (or [15:8] if COMPRESSED); if COMPRESSED=0, the FSM then goes to W_HIGH.
REQ-018 In W_IDLE, pcm_valid_i && capturing && fifo_full_i SHALL drop the sample: no write, drop_count_o+1, overflow_o=1.
REQ-019 In W_HIGH, while !fifo_full_i, the FSM SHALL write the latched high byte and return to W_IDLE; while full it SHALL stall in W_HIGH without writing.
REQ-020 pcm_valid_i arriving in W_HIGH SHALL count as a drop; a byte pair is never split or interleaved.
REQ-021 STOP in W_HIGH SHALL allow the pending high byte to complete.
REQ-022 drop_count_o SHALL saturate at 16'hFFFF.
REQ-023 A drop and CLR in the same cycle SHALL leave overflow_o=1 and drop_count_o=1 (the drop wins).
REQ-024 spi_busy_i SHALL pass through a 2-FF synchronizer plus a third edge register; a rise is flagged in cycle E.
REQ-025 The reader FSM SHALL have states R_IDLE, R_READ and R_LOAD.
REQ-026 In R_IDLE at a rise with the FIFO not empty, the FSM SHALL assert fifo_rd_en_o for exactly one cycle (E+1, state R_READ), then in R_LOAD (E+2) load spi_tx_data_o=fifo_rd_data_i, pulse spi_tx_valid_o and return to R_IDLE.
REQ-027 In R_IDLE at a rise with fifo_empty_i, the FSM SHALL load spi_tx_data_o=FILL_BYTE with spi_tx_valid_o in cycle E+1 and never assert fifo_rd_en_o.
REQ-028 A busy rise flagged while in R_READ or R_LOAD SHALL be ignored.
REQ-029 fifo_rd_en_o SHALL never assert while fifo_empty_i=1 in the same cycle.
REQ-030 The writer and reader SHALL run independently; a simultaneous FIFO write and read is legal.
REQ-031 spi_tx_data_o SHALL hold its value between loads.

Reset
REQ-032 rst SHALL put both FSMs in W_IDLE/R_IDLE and clear the synchronizer.
REQ-033 rst SHALL force all outputs to 0: capturing_o, overflow_o, drop_count_o, fifo_wr_en_o, fifo_rd_en_o, spi_tx_valid_o and spi_tx_data_o (8'h00).
REQ-034 rst mid-pair SHALL abandon the pending high byte.
REQ-035 rst SHALL take priority over every concurrent event.

Structure
REQ-036 Package pdm_stream_pkg SHALL hold the command codes, the writer_state_t and reader_state_t enums, and the FILL_BYTE default.
REQ-037 The synchronizer plus rise detect SHALL be one sub-module, sync_rise_detect.

Verification
REQ-038 START, then pcm 16'hBEEF (COMPRESSED=0, FIFO not full) -> writes 8'hEF then 8'hBE on consecutive-or-later cycles, with drop_count_o=0.
REQ-039 fifo_full_i=1 plus 3 pcm strobes while capturing -> no writes, drop_count_o=3, overflow_o=1; then CLR -> both 0.
REQ-040 FIFO holds 8'h5A and spi_busy_i rises -> fifo_rd_en_o at E+1 only, spi_tx_data_o=8'h5A with spi_tx_valid_o at E+2.
REQ-041 FIFO empty and spi_busy_i rises -> spi_tx_data_o=8'h00 with spi_tx_valid_o at E+1, and fifo_rd_en_o never asserted.
REQ-042 fifo_full_i held while in W_HIGH, a pcm strobe arrives, then full releases -> high byte written once, drop_count_o=1.
REQ-043 rst asserted in W_HIGH -> all outputs 0 next cycle, and no high-byte write afterwards.

Source files
------------

// File: rtl/pdm_stream_pkg.sv
// pdm_stream_pkg: command codes, FSM state types and defaults shared by the PDM stream controller
package pdm_stream_pkg;
  localparam logic [7:0] CMD_START         = 8'h01;
  localparam logic [7:0] CMD_STOP          = 8'h02;
  localparam logic [7:0] CMD_CLR           = 8'h03;
  localparam logic [7:0] FILL_BYTE_DEFAULT = 8'h00;
  typedef enum logic {W_IDLE, W_HIGH} writer_state_t;
  typedef enum logic [1:0] {R_IDLE, R_READ, R_LOAD} reader_state_t;
endpackage

// File: rtl/sync_rise_detect.sv
// sync_rise_detect: two-flop synchronizer plus an edge register flagging a rising edge of an async input
module sync_rise_detect (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic rise
);
  logic [2:0] sync_q;
  always_ff @(posedge clk) begin
    if (rst) sync_q <= '0;
    else     sync_q <= {sync_q[1:0], d};
  end
  assign rise = sync_q[1] & ~sync_q[2];
endmodule

// File: rtl/pdm_stream_ctrl.sv
// pdm_stream_ctrl: packs PCM samples into a byte FIFO and hands FIFO bytes to an SPI slave on busy rises
module pdm_stream_ctrl
  import pdm_stream_pkg::*;
#(
  parameter bit         COMPRESSED = 1'b0,
  parameter logic [7:0] FILL_BYTE  = FILL_BYTE_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        pcm_valid_i,
  input  logic [15:0] pcm_data_i,
  input  logic        spi_busy_i,
  input  logic        spi_rx_valid_i,
  input  logic [7:0]  spi_rx_data_i,
  output logic [7:0]  spi_tx_data_o,
  output logic        spi_tx_valid_o,
  output logic        fifo_wr_en_o,
  output logic [7:0]  fifo_wr_data_o,
  input  logic        fifo_full_i,
  output logic        fifo_rd_en_o,
  input  logic [7:0]  fifo_rd_data_i,
  input  logic        fifo_empty_i,
  output logic        capturing_o,
  output logic        overflow_o,
  output logic [15:0] drop_count_o
);
  writer_state_t w_state, w_next;
  reader_state_t r_state, r_next;
  logic        cmd_start, cmd_stop, cmd_clr, take, drop, busy_rise;
  logic        fill_q, fill_d, wr_en_d, capturing_d, overflow_d;
  logic [7:0]  hi_q, hi_d, wr_data_d, tx_q, tx_d;
  logic [15:0] drop_d;

  sync_rise_detect u_busy (
    .clk  (clk),
    .rst  (rst),
    .d    (spi_busy_i),
    .rise (busy_rise)
  );

  assign cmd_start   = spi_rx_valid_i && spi_rx_data_i == CMD_START;
  assign cmd_stop    = spi_rx_valid_i && spi_rx_data_i == CMD_STOP;
  assign cmd_clr     = spi_rx_valid_i && spi_rx_data_i == CMD_CLR;
  assign take        = w_state == W_IDLE && pcm_valid_i && capturing_o && !fifo_full_i;
  // a sample is lost when the FIFO is full or a byte pair is still in flight
  assign drop        = pcm_valid_i && capturing_o && (w_state == W_HIGH || fifo_full_i);
  assign capturing_d = cmd_start ? 1'b1 : cmd_stop ? 1'b0 : capturing_o;
  assign overflow_d  = drop | (overflow_o & ~cmd_clr);
  assign drop_d      = drop ? (cmd_clr ? 16'd1 : drop_count_o + 16'(drop_count_o != 16'hFFFF))
                            : (cmd_clr ? 16'd0 : drop_count_o);

  always_comb begin
    w_next    = w_state;
    wr_en_d   = 1'b0;
    wr_data_d = fifo_wr_data_o;
    hi_d      = hi_q;
    if (take) begin
      wr_en_d   = 1'b1;
      wr_data_d = COMPRESSED ? pcm_data_i[15:8] : pcm_data_i[7:0];
      hi_d      = pcm_data_i[15:8];
      w_next    = COMPRESSED ? W_IDLE : W_HIGH;
    end else if (w_state == W_HIGH && !fifo_full_i) begin
      wr_en_d   = 1'b1;
      wr_data_d = hi_q;
      w_next    = W_IDLE;
    end
  end

  always_comb begin
    r_next = R_IDLE;
    fill_d = 1'b0;
    if (r_state == R_IDLE && busy_rise) begin
      r_next = fifo_empty_i ? R_IDLE : R_READ;
      fill_d = fifo_empty_i;
    end else if (r_state == R_READ) r_next = R_LOAD;
    tx_d = r_state == R_LOAD ? fifo_rd_data_i : fill_d ? FILL_BYTE : tx_q;
  end

  // FIFO read data arrives during R_LOAD, so it is forwarded straight out and kept in tx_q afterwards
  assign fifo_rd_en_o   = r_state == R_READ && !fifo_empty_i;
  assign spi_tx_valid_o = r_state == R_LOAD || fill_q;
  assign spi_tx_data_o  = r_state == R_LOAD ? fifo_rd_data_i : tx_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      w_state        <= W_IDLE;
      r_state        <= R_IDLE;
      capturing_o    <= 1'b0;
      overflow_o     <= 1'b0;
      drop_count_o   <= '0;
      fifo_wr_en_o   <= 1'b0;
      fifo_wr_data_o <= '0;
      hi_q           <= '0;
      tx_q           <= '0;
      fill_q         <= 1'b0;
    end else begin
      w_state        <= w_next;
      r_state        <= r_next;
      capturing_o    <= capturing_d;
      overflow_o     <= overflow_d;
      drop_count_o   <= drop_d;
      fifo_wr_en_o   <= wr_en_d;
      fifo_wr_data_o <= wr_data_d;
      hi_q           <= hi_d;
      tx_q           <= tx_d;
      fill_q         <= fill_d;
    end
  end
endmodule
